// File: rtl/wash_pkg.sv
// Shared definitions for the washer front panel: FSM encoding, program table and
// power-on defaults.
package wash_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_IDLE  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int         PROG_CNT  = 6;
  localparam logic [2:0] PROG_LAST = 3'(PROG_CNT - 1);
  localparam logic [2:0] DEF_PROG  = 3'd0;
  localparam logic [5:0] DEF_TIME  = 6'd33;

  function automatic logic [2:0] next_prog(input logic [2:0] cur);
    return (cur == PROG_LAST) ? 3'd0 : cur + 3'd1;
  endfunction

  function automatic logic [5:0] prog_time(input logic [2:0] idx);
    case (idx)
      3'd0:    return 6'd33;
      3'd1:    return 6'd30;
      3'd2:    return 6'd15;
      3'd3:    return 6'd12;
      3'd4:    return 6'd21;
      3'd5:    return 6'd6;
      default: return DEF_TIME;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: level follows raw after DB_CYC consecutive differing samples;
// press is a one-cycle pulse on the debounced rising edge.
module key_debounce #(
  parameter int DB_CYC = 4
) (
  input  logic ts,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge ts or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      press <= 1'b0;
      if (raw != level) begin
        // The DB_CYC-th differing sample commits the new level.
        if (cnt == CW'(DB_CYC - 1)) begin
          level <= raw;
          press <= raw;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/wash_panel.sv
// Washer front panel: debounced keys drive an OFF/IDLE/RUN/PAUSE/DONE controller.
// Optional idle auto power-off is enabled with WASH_PANEL_AUTO_OFF_EN.
module wash_panel #(
  parameter int DB_CYC   = 4,
  parameter int BEEP_CYC = 8,
  parameter int IDLE_TO  = 60
) (
  input  logic       ts,
  input  logic       rst,
  input  logic       k_pwr,
  input  logic       k_mod,
  input  logic       k_start,
  input  logic [5:0] Tt,
  output logic       p,
  output logic       mod,
  output logic       s,
  output logic [2:0] mod1,
  output logic [5:0] Tt1,
  output logic       beep,
  output logic [2:0] state_dbg
);

  import wash_pkg::*;

  localparam int BW = $clog2(BEEP_CYC + 1);

  state_t        state, state_n;
  logic [2:0]    mod1_n;
  logic [5:0]    tt1_n;
  logic          mod_pend, mod_pend_n;
  logic          armed, armed_n;
  logic [BW-1:0] beep_cnt, beep_cnt_n;
  logic          pwr_ev, mod_ev, start_ev;
  logic [2:0]    unused_level;

  key_debounce #(.DB_CYC(DB_CYC)) u_db_pwr (
    .ts(ts), .rst(rst), .raw(k_pwr), .level(unused_level[0]), .press(pwr_ev)
  );
  key_debounce #(.DB_CYC(DB_CYC)) u_db_mod (
    .ts(ts), .rst(rst), .raw(k_mod), .level(unused_level[1]), .press(mod_ev)
  );
  key_debounce #(.DB_CYC(DB_CYC)) u_db_start (
    .ts(ts), .rst(rst), .raw(k_start), .level(unused_level[2]), .press(start_ev)
  );

`ifdef WASH_PANEL_AUTO_OFF_EN
  localparam int IW = $clog2(IDLE_TO + 1);
  logic [IW-1:0] idle_cnt, idle_cnt_n;
`else
  logic unused_idle_to;
  assign unused_idle_to = (IDLE_TO != 0);
`endif

  assign p         = (state != S_OFF);
  assign s         = (state == S_RUN);
  assign beep      = (state == S_DONE);
  assign state_dbg = state;

  always_ff @(posedge ts or posedge rst) begin
    if (rst) begin
      state    <= S_OFF;
      mod1     <= DEF_PROG;
      Tt1      <= DEF_TIME;
      mod_pend <= 1'b0;
      mod      <= 1'b0;
      armed    <= 1'b0;
      beep_cnt <= '0;
`ifdef WASH_PANEL_AUTO_OFF_EN
      idle_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      mod1     <= mod1_n;
      Tt1      <= tt1_n;
      mod_pend <= mod_pend_n;
      mod      <= mod_pend;
      armed    <= armed_n;
      beep_cnt <= beep_cnt_n;
`ifdef WASH_PANEL_AUTO_OFF_EN
      idle_cnt <= idle_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    mod1_n     = mod1;
    tt1_n      = Tt1;
    mod_pend_n = 1'b0;
    armed_n    = armed;
    beep_cnt_n = beep_cnt;
`ifdef WASH_PANEL_AUTO_OFF_EN
    idle_cnt_n = idle_cnt;
`endif
    // Power wins over everything; other events that cycle are dropped.
    if (state != S_OFF && pwr_ev) begin
      state_n    = S_OFF;
      mod1_n     = DEF_PROG;
      tt1_n      = DEF_TIME;
      armed_n    = 1'b0;
      beep_cnt_n = '0;
    end else begin
      case (state)
        S_OFF: begin
          if (pwr_ev) begin
            state_n = S_IDLE;
            armed_n = 1'b0;
`ifdef WASH_PANEL_AUTO_OFF_EN
            idle_cnt_n = '0;
`endif
          end
        end
        S_IDLE: begin
          if (start_ev) begin
            state_n = S_RUN;
          end else if (mod_ev) begin
            mod1_n     = next_prog(mod1);
            tt1_n      = prog_time(next_prog(mod1));
            mod_pend_n = 1'b1;
`ifdef WASH_PANEL_AUTO_OFF_EN
            idle_cnt_n = '0;
`endif
          end
`ifdef WASH_PANEL_AUTO_OFF_EN
          else if (idle_cnt == IW'(IDLE_TO - 1)) begin
            state_n = S_OFF;
            mod1_n  = DEF_PROG;
            tt1_n   = DEF_TIME;
            armed_n = 1'b0;
          end else begin
            idle_cnt_n = idle_cnt + 1'b1;
          end
`endif
        end
        S_RUN: begin
          // Completion needs the controller to have reported a load first.
          armed_n = armed | (Tt != 6'd0);
          if (start_ev) begin
            state_n = S_PAUSE;
          end else if (armed && Tt == 6'd0) begin
            state_n    = S_DONE;
            beep_cnt_n = '0;
          end
        end
        S_PAUSE: begin
          if (start_ev) state_n = S_RUN;
        end
        S_DONE: begin
          if (start_ev || mod_ev || beep_cnt == BW'(BEEP_CYC - 1)) begin
            state_n = S_IDLE;
            armed_n = 1'b0;
`ifdef WASH_PANEL_AUTO_OFF_EN
            idle_cnt_n = '0;
`endif
          end else begin
            beep_cnt_n = beep_cnt + 1'b1;
          end
        end
        default: state_n = S_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_wash_panel.sv
// Self-checking bench for wash_panel: key driver tasks, a scoreboard queue of
// expected {mod1,Tt1} values for each mod strobe, and a final report.
module tb_wash_panel;

  import wash_pkg::*;

  logic       ts = 1'b0;
  logic       rst = 1'b1;
  logic       k_pwr = 1'b0, k_mod = 1'b0, k_start = 1'b0;
  logic [5:0] Tt = 6'd0;
  logic       p, mod, s, beep;
  logic [2:0] mod1, state_dbg;
  logic [5:0] Tt1;

  int tests = 0;
  int fails = 0;
  int m_prog = 0;
  int tbl[6] = '{33, 30, 15, 12, 21, 6};
  logic [8:0] exp_q[$];

  wash_panel dut (
    .ts(ts), .rst(rst), .k_pwr(k_pwr), .k_mod(k_mod), .k_start(k_start),
    .Tt(Tt), .p(p), .mod(mod), .s(s), .mod1(mod1), .Tt1(Tt1), .beep(beep),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 ts = ~ts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // scoreboard: every mod strobe must match the next queued {mod1,Tt1}
  always @(negedge ts) begin
    if (mod === 1'b1) begin
      if (exp_q.size() == 0) check("mod_spurious", 32'd1, 32'd0);
      else check("mod_pulse", {23'd0, mod1, Tt1}, {23'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge ts);
    #1;
  endtask

  task automatic press(input int which, input int hold);
    case (which)
      0: k_pwr = 1'b1;
      1: k_mod = 1'b1;
      default: k_start = 1'b1;
    endcase
    tick(hold);
    k_pwr = 1'b0; k_mod = 1'b0; k_start = 1'b0;
    tick(6);
  endtask

  task automatic mode_press_exp();
    m_prog = (m_prog + 1) % 6;
    exp_q.push_back({3'(m_prog), 6'(tbl[m_prog])});
    press(1, 6 + $urandom_range(0, 2));
    check("mod1_step", 32'(mod1), 32'(m_prog));
    check("tt1_step", 32'(Tt1), 32'(tbl[m_prog]));
  endtask

  task automatic check_idle_defaults(input string tag);
    check({tag, "_p"}, 32'(p), 32'd0);
    check({tag, "_s"}, 32'(s), 32'd0);
    check({tag, "_mod1"}, 32'(mod1), 32'd0);
    check({tag, "_tt1"}, 32'(Tt1), 32'd33);
    check({tag, "_beep"}, 32'(beep), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(S_OFF));
  endtask

  initial begin
    int n;
    bit found;
    tick(3);
    check_idle_defaults("rst");
    check("rst_mod", 32'(mod), 32'd0);
    rst = 1'b0;
    tick(2);

    // short pulse rejected, long press powers on
    press(0, 3);
    check("pwr_short_p", 32'(p), 32'd0);
    press(0, 6);
    check("pwr_long_p", 32'(p), 32'd1);
    check("pwr_long_state", 32'(state_dbg), 32'(S_IDLE));

    // full program cycle including wrap, then select program 4
    for (int i = 0; i < 10; i++) mode_press_exp();

    press(2, 6);
    check("run_s", 32'(s), 32'd1);
    press(1, 6);
    check("run_mod_ignored", 32'(mod1), 32'd4);
    check("run_tt1_kept", 32'(Tt1), 32'd21);
    press(2, 6);
    check("pause_s", 32'(s), 32'd0);
    check("pause_state", 32'(state_dbg), 32'(S_PAUSE));
    press(2, 6);
    check("resume_s", 32'(s), 32'd1);

    // Tt==0 before any load must not complete
    tick(5);
    check("unarmed_state", 32'(state_dbg), 32'(S_RUN));
    Tt = 6'd21;
    tick(3);
    Tt = 6'd0;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      tick(1);
      if (beep === 1'b1) found = 1;
    end
    check("beep_seen", 32'(found), 32'd1);
    check("done_s", 32'(s), 32'd0);
    n = 0;
    while (beep === 1'b1 && n < 20) begin
      n++;
      tick(1);
    end
    check("beep_len", 32'(n), 32'd8);
    check("after_beep_state", 32'(state_dbg), 32'(S_IDLE));
    check("retain_mod1", 32'(mod1), 32'd4);
    check("retain_tt1", 32'(Tt1), 32'd21);

    // mode press during beep ends it early and is consumed
    press(2, 6);
    Tt = 6'(1 + $urandom_range(0, 40));
    tick(2);
    Tt = 6'd0;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      tick(1);
      if (beep === 1'b1) found = 1;
    end
    check("beep2_seen", 32'(found), 32'd1);
    k_mod = 1'b1;
    tick(5);
    check("abort_beep", 32'(beep), 32'd0);
    check("abort_state", 32'(state_dbg), 32'(S_IDLE));
    k_mod = 1'b0;
    tick(6);
    check("abort_mod1", 32'(mod1), 32'd4);

    // power and start in the same cycle: power wins
    k_pwr = 1'b1; k_start = 1'b1;
    tick(6);
    k_pwr = 1'b0; k_start = 1'b0;
    tick(6);
    check_idle_defaults("pwr_start");
    m_prog = 0;

    // asynchronous reset mid-run
    press(0, 6);
    mode_press_exp();
    press(2, 6);
    Tt = 6'd7;
    tick(2);
    #3 rst = 1'b1;
    #1 check_idle_defaults("async_rst");
    tick(2);
    rst = 1'b0;
    Tt = 6'd0;
    m_prog = 0;
    tick(2);

    // reset between mod1 update and mod strobe: no residual strobe
    press(0, 6);
    k_mod = 1'b1;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick(1);
      if (mod1 != 3'd0) found = 1;
    end
    check("mod_upd_seen", 32'(found), 32'd1);
    #2 rst = 1'b1;
    k_mod = 1'b0;
    k_pwr = 1'b1;
    tick(2);
    check("rst2_mod1", 32'(mod1), 32'd0);
    // key held across reset release
    rst = 1'b0;
    tick(3);
    check("held_pwr_early", 32'(p), 32'd0);
    tick(3);
    check("held_pwr_late", 32'(p), 32'd1);
    k_pwr = 1'b0;
    tick(6);

`ifdef WASH_PANEL_AUTO_OFF_EN
    press(0, 6);
    press(0, 6);
    tick(45);
    check("autooff_before", 32'(p), 32'd1);
    tick(15);
    check("autooff_after", 32'(p), 32'd0);
    check("autooff_tt1", 32'(Tt1), 32'd33);
`else
    tick(200);
    check("no_autooff_p", 32'(p), 32'd1);
`endif

    tick(4);
    check("mod_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
